// File: rtl/uart_rx_fifo_if.sv
// Output stream of the UART receive FIFO: first-word-fall-through valid/ready handshake.
interface uart_rx_fifo_if #(
  parameter int unsigned WORD_SIZE = 8
);

  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;

  // FIFO side: presents the oldest word and samples the consumer's ready
  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  // Consumer side
  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface : uart_rx_fifo_if

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures a word on each rising edge of the receiver-idle flag
// and buffers it in a first-word-fall-through FIFO with sticky overflow reporting.
// Optional feature macro: UART_RX_OVF_COUNT_EN enables a saturating dropped-word
// counter on ovf_cnt; when undefined ovf_cnt is tied to zero.
module uart_rx_fifo #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_valid,
  input  logic [WORD_SIZE-1:0]   data_bits,
  uart_rx_fifo_if.master         out_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic [7:0]             ovf_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                 rx_valid_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 full_q, full_d;
  logic                 overflow_q, overflow_d;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  logic word_done_c;
  logic rd_c;
  logic wr_c;
  logic drop_c;

  // Event decode: a word completes when the receiver returns to idle
  always_comb begin
    word_done_c = rx_valid & ~rx_valid_q;
    rd_c        = valid_q & out_if.out_ready;
    // A full FIFO still accepts a word when a read frees a slot in the same cycle
    wr_c        = word_done_c & (~full_q | rd_c);
    drop_c      = word_done_c & full_q & ~rd_c;
  end

  // Next-state for pointers, occupancy, flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({wr_c, rd_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set
    if (drop_c)       overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;

    valid_d = (count_d != CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // Control state; rx_valid_q resets high so release of reset is not a word-done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_valid_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage; contents are don't-care after reset since pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_c) mem_q[wr_ptr_q] <= data_bits;
  end

`ifdef UART_RX_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating dropped-word counter; a drop coincident with clear restarts at one
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop_c) begin
      if (clr_ovf)                 ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      ovf_cnt_d = 8'd0;
    end
  end

  // Dropped-word counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_cnt_q <= 8'd0;
    else       ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'd0;
`endif

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign count            = count_q;
  assign full             = full_q;
  assign overflow         = overflow_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset, capture latency, overflow, full+read, clear, mid-stream reset.
module tb_uart_rx_fifo;

`ifdef UART_RX_OVF_COUNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_valid;
  logic [7:0] data_bits;
  logic [3:0] count;
  logic       full;
  logic       overflow;
  logic       clr_ovf;
  logic [7:0] ovf_cnt;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo_if #(.WORD_SIZE(8)) out_if ();

  uart_rx_fifo #(.WORD_SIZE(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .data_bits (data_bits),
    .out_if    (out_if),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver goes busy for one cycle then returns idle with the word on data_bits
  task automatic send_word(input logic [7:0] d);
    rx_valid = 1'b0;
    tick();
    data_bits = d;
    rx_valid  = 1'b1;
    tick();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b1; data_bits = 8'h00;
    out_if.out_ready = 1'b0; clr_ovf = 1'b0;
    #3;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_if.out_valid); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_flags full=%0b ovf=%0b exp=0/0", full, overflow); end
    checks++; if (ovf_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovfcnt got=%0d exp=0", ovf_cnt); end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (count !== 4'd0 || out_if.out_valid !== 1'b0) begin failures++; $display("FAIL idle_no_write count=%0d valid=%0b exp=0/0", count, out_if.out_valid); end
  endtask

  task automatic test_single_word();
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (out_if.out_valid !== 1'b0) begin failures++; $display("FAIL busy_valid got=%0b exp=0", out_if.out_valid); end
    data_bits = 8'hA5; rx_valid = 1'b1;
    tick();
    checks++; if (out_if.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_if.out_valid); end
    checks++; if (out_if.out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h exp=a5", out_if.out_data); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    tick();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_no_rewrite got=%0d exp=1", count); end
    out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
    checks++; if (count !== 4'd0 || out_if.out_valid !== 1'b0) begin failures++; $display("FAIL single_read count=%0d valid=%0b exp=0/0", count, out_if.out_valid); end
    // ready on an empty FIFO must not underflow
    out_if.out_ready = 1'b1;
    tick(); tick();
    out_if.out_ready = 1'b0;
    checks++; if (count !== 4'd0 || out_if.out_valid !== 1'b0) begin failures++; $display("FAIL empty_ready count=%0d valid=%0b exp=0/0", count, out_if.out_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) send_word(8'(i));
    checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fill count=%0d full=%0b exp=8/1", count, full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf got=%0b exp=0", overflow); end
    send_word(8'h09);
    checks++; if (overflow !== 1'b1 || full !== 1'b1) begin failures++; $display("FAIL drop_flags ovf=%0b full=%0b exp=1/1", overflow, full); end
    checks++; if (out_if.out_data !== 8'h01) begin failures++; $display("FAIL drop_head got=%0h exp=01", out_if.out_data); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL drop_count got=%0d exp=8", count); end
    checks++; if (ovf_cnt !== (OVF_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL drop_ovfcnt got=%0d exp=%0d", ovf_cnt, OVF_EN ? 1 : 0); end
  endtask

  task automatic test_full_read_write();
    rx_valid = 1'b0;
    tick();
    data_bits = 8'h09; rx_valid = 1'b1; out_if.out_ready = 1'b1;
    tick();
    out_if.out_ready = 1'b0;
    checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL fullrw_count count=%0d full=%0b exp=8/1", count, full); end
    checks++; if (out_if.out_data !== 8'h02) begin failures++; $display("FAIL fullrw_head got=%0h exp=02", out_if.out_data); end
    out_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'(2 + i)) begin
        failures++;
        $display("FAIL drain_%0d valid=%0b data=%0h exp=1/%0h", i, out_if.out_valid, out_if.out_data, 2 + i);
      end
      tick();
    end
    out_if.out_ready = 1'b0;
    checks++; if (count !== 4'd0 || out_if.out_valid !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL drain_empty count=%0d valid=%0b full=%0b exp=0/0/0", count, out_if.out_valid, full); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || ovf_cnt !== 8'd0) begin failures++; $display("FAIL clr ovf=%0b cnt=%0d exp=0/0", overflow, ovf_cnt); end
  endtask

  task automatic test_clr_with_drop();
    for (int i = 1; i <= 8; i++) send_word(8'(8'h10 + i));
    rx_valid = 1'b0;
    tick();
    data_bits = 8'hAA; rx_valid = 1'b1; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_drop_ovf got=%0b exp=1", overflow); end
    checks++; if (ovf_cnt !== (OVF_EN ? 8'd1 : 8'd0)) begin failures++; $display("FAIL clr_drop_cnt got=%0d exp=%0d", ovf_cnt, OVF_EN ? 1 : 0); end
    checks++; if (count !== 4'd8 || out_if.out_data !== 8'h11) begin failures++; $display("FAIL clr_drop_store count=%0d head=%0h exp=8/11", count, out_if.out_data); end
  endtask

  task automatic test_ovf_saturate();
    for (int i = 0; i < 300; i++) send_word(8'(i));
    checks++; if (ovf_cnt !== (OVF_EN ? 8'd255 : 8'd0)) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", ovf_cnt, OVF_EN ? 255 : 0); end
    checks++; if (overflow !== 1'b1 || out_if.out_data !== 8'h11 || count !== 4'd8) begin failures++; $display("FAIL sat_state ovf=%0b head=%0h count=%0d exp=1/11/8", overflow, out_if.out_data, count); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || ovf_cnt !== 8'd0) begin failures++; $display("FAIL sat_clr ovf=%0b cnt=%0d exp=0/0", overflow, ovf_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_word(8'h21); send_word(8'h22); send_word(8'h23);
    checks++; if (count !== 4'd3) begin failures++; $display("FAIL mid_store got=%0d exp=3", count); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || out_if.out_valid !== 1'b0) begin failures++; $display("FAIL mid_async count=%0d valid=%0b exp=0/0", count, out_if.out_valid); end
    tick();
    rstn = 1'b1;
    tick();
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_release got=%0d exp=0", count); end
    send_word(8'h3C);
    checks++; if (count !== 4'd1 || out_if.out_data !== 8'h3C) begin failures++; $display("FAIL mid_next count=%0d data=%0h exp=1/3c", count, out_if.out_data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_full_read_write();
    test_clr_with_drop();
    test_ovf_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 8, the width of one received word.
REQ-002 The module SHALL have parameter DEPTH, default 8, the number of stored words (power of 2, >=2).
REQ-003 The module SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rstn, input, 1, the asynchronous active-low reset.
REQ-005 The module SHALL have port rx_valid, input, 1, the receiver-idle flag (high = receiver idle/ready).
REQ-006 The module SHALL have port data_bits, input, WORD_SIZE, the receiver's assembled word.
REQ-007 The module SHALL have port out_valid, output, 1, high when a word is available.
REQ-008 The module SHALL have port out_ready, input, 1, consumer accepts out_data this cycle.
REQ-009 The module SHALL have port out_data, output, WORD_SIZE, the oldest stored word.
REQ-010 The module SHALL have port count, output, $clog2(DEPTH)+1, the number of stored words.
REQ-011 The module SHALL have port full, output, 1, high when count==DEPTH.
REQ-012 The module SHALL have port overflow, output, 1, the sticky word-dropped flag.
REQ-013 The module SHALL have port clr_ovf, input, 1, a one-cycle pulse clearing overflow (and ovf_cnt).
REQ-014 The module SHALL have port ovf_cnt, output, 8, the dropped-word counter (see Configuration).

Function
REQ-015 rx_valid SHALL be registered into rx_valid_q every cycle; a word-done event SHALL be rx_valid & ~rx_valid_q.
REQ-016 On a word-done event the value of data_bits sampled at that same clock edge SHALL be the word written.
REQ-017 A write SHALL be accepted when count<DEPTH, or when count==DEPTH and a read occurs in the same cycle.
REQ-018 A read SHALL occur when out_valid && out_ready; out_ready while out_valid is low SHALL have no effect.
REQ-019 Storage SHALL be first-word-fall-through: out_data = oldest word whenever out_valid is high, stable until read.
REQ-020 out_valid SHALL be (count!=0), first asserting the cycle after the first accepted write (1-cycle latency).
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-022 count SHALL be +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-023 A word-done event with count==DEPTH and no read SHALL drop the word, leave storage unchanged, and set overflow.
REQ-024 If clr_ovf coincides with a drop, overflow SHALL remain set (drop wins).
REQ-025 out_data SHALL be undefined-but-stable while out_valid is low; the bench SHALL not check it.

Reset
REQ-026 Asserting rstn low SHALL immediately clear pointers, count, overflow, and ovf_cnt; out_valid=0, full=0.
REQ-027 During reset, rx_valid_q SHALL be 1, so that no word-done event fires on the first cycle after reset.
REQ-028 Reset mid-operation SHALL discard all stored words; storage contents need not be cleared.

Configuration
REQ-029 Macro UART_RX_OVF_COUNT_EN defined: ovf_cnt SHALL increment per dropped word, saturating at 255.
REQ-030 With UART_RX_OVF_COUNT_EN defined, clr_ovf SHALL zero ovf_cnt; a coincident drop SHALL leave ovf_cnt=1.
REQ-031 Macro UART_RX_OVF_COUNT_EN undefined: ovf_cnt SHALL be tied to 0, with no counter logic; overflow is unaffected.

Verification
REQ-032 Reset, then hold rx_valid=1 for 10 cycles -> count=0, out_valid=0, no write.
REQ-033 Drop rx_valid for 3 cycles, then raise it with data_bits=0xA5, out_ready=0 -> out_valid=1 the next cycle, out_data=0xA5, count=1.
REQ-034 Send 0x01..0x08 with out_ready=0, then 0x09 -> full=1, overflow=1, out_data=0x01; with the macro defined, ovf_cnt=1.
REQ-035 With the FIFO full, word-done coincident with a read -> 0x09 accepted, count stays 8; drain order is 0x02..0x09.
REQ-036 With macro defined, force 300 drops, then pulse clr_ovf -> ovf_cnt=255, then overflow=0 and ovf_cnt=0.
REQ-037 Store 3 words, assert rstn low mid-stream -> count=0 and out_valid=0 immediately; the next word 0x3C is read first.
